// File: rtl/maxpool_2x2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : maxpool_2x2_stream                                         |
// | Description : Streaming 2x2 signed max-pooling over a row-major frame,   |
// |               one line buffer of horizontal maxima, valid/ready I/O.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module maxpool_2x2_stream #(
    parameter int DATA_BITS = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [DATA_BITS-1:0] in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic signed [DATA_BITS-1:0] out_data,
    input  logic                        out_ready,
    output logic                        frame_done
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);

    logic [CW-1:0]               r_col;
    logic [RW-1:0]               r_row;
    logic signed [DATA_BITS-1:0] r_pa;
    logic signed [DATA_BITS-1:0] r_lb [LB_DEPTH];
    logic                        r_out_valid;
    logic signed [DATA_BITS-1:0] r_out_data;
    logic                        r_frame_done;

    logic                        w_in_fire;
    logic                        w_out_fire;
    logic                        w_col_odd;
    logic                        w_row_odd;
    logic                        w_col_last;
    logic                        w_row_last;
    logic                        w_load;
    logic                        w_lb_wr;
    logic [LW-1:0]               w_lb_idx;
    logic signed [DATA_BITS-1:0] w_hmax;
    logic signed [DATA_BITS-1:0] w_lb_rd;
    logic signed [DATA_BITS-1:0] w_vmax;

    // A held, unaccepted result blocks input so no pixel is ever dropped.
    assign in_ready   = !(r_out_valid && !out_ready);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == c_col_last);
    assign w_row_last = (r_row == c_row_last);
    assign w_lb_idx   = LW'(r_col >> 1);

    assign w_hmax  = (in_data > r_pa) ? in_data : r_pa;
    assign w_lb_rd = r_lb[w_lb_idx];
    assign w_vmax  = (w_hmax > w_lb_rd) ? w_hmax : w_lb_rd;

    assign w_load  = w_in_fire && w_col_odd && w_row_odd;
    assign w_lb_wr = w_in_fire && w_col_odd && !w_row_odd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_pa         <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_load && w_col_last && w_row_last;

            if (w_in_fire) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (!w_col_odd) begin
                    r_pa <= in_data;
                end
            end

            // A new load wins over an unload in the same cycle.
            if (w_load) begin
                r_out_data  <= w_vmax;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Each even row fully rewrites the buffer before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            r_lb[w_lb_idx] <= w_hmax;
        end
    end

endmodule
`default_nettype wire

// File: doc/maxpool_2x2_stream.md
MAXPOOL_2X2_STREAM -- requirements
Module: maxpool_2x2_stream

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, meaning pixel width in two's-complement signed format.
REQ-002 The module SHALL have parameter IMG_W, default 28, meaning input row length in pixels; it must be even and at least 2.
REQ-003 The module SHALL have parameter IMG_H, default 28, meaning input rows per frame; it must be even and at least 2.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream pixel is valid.
REQ-007 The module SHALL have port in_data, input, DATA_BITS bits: signed input pixel, delivered in row-major order.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the module can accept a pixel.
REQ-009 The module SHALL have port out_valid, output, 1 bit: a pooled pixel is held on out_data.
REQ-010 The module SHALL have port out_data, output, DATA_BITS bits: signed pooled pixel, in row-major order of an (IMG_W/2) x (IMG_H/2) frame.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the end of a frame.

Function
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 in_ready SHALL equal !(out_valid && !out_ready), so a stalled output blocks input and no pixel is dropped.
REQ-015 The module SHALL keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1), both advancing only on input transfers.
- At col = IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
- At row = IMG_H-1 with col = IMG_W-1, row SHALL wrap to 0.
REQ-016 On an even col, the module SHALL latch in_data into pair register pa.
REQ-017 On an odd col, the module SHALL compute hmax = signed max(pa, in_data); on a tie it returns either operand, since the values are equal.
REQ-018 On an even row, at odd col, the module SHALL write hmax into line buffer lb[col>>1] (IMG_W/2 entries x DATA_BITS); no output is produced.
REQ-019 On an odd row, at odd col, the module SHALL load out_data with signed max(hmax, lb[col>>1]) and set out_valid on the following cycle (latency 1 cycle from the transfer of the second pixel of the pair).
REQ-020 out_valid SHALL clear after an output transfer unless a new result is loaded in the same cycle; a load and an unload in the same cycle SHALL leave out_valid high with the new data.
REQ-021 out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-022 All comparisons SHALL be signed over the full DATA_BITS width; no widening or saturation is applied.
REQ-023 frame_done SHALL pulse high for exactly one cycle, in the same cycle out_valid first asserts for the last pooled pixel of the frame (row = IMG_H-1, col = IMG_W-1).
REQ-024 Frames SHALL be processed back-to-back with no idle cycles required between them; lb contents from a previous frame are overwritten before use.
REQ-025 in_valid arriving while in_ready is low SHALL not advance any counter or register.

Reset
REQ-026 While reset is high on a rising edge, col, row, pa, out_data, out_valid and frame_done SHALL clear to 0; lb need not be cleared.
REQ-027 in_ready SHALL be 1 in the first cycle after reset.
REQ-028 A reset mid-frame SHALL discard the partial frame, and the next accepted pixel SHALL be treated as row 0, col 0.

Verification
REQ-029 With IMG_W=4, IMG_H=2, out_ready=1, feed row 0 = {1,5,-3,2} and row 1 = {4,0,-7,-1}; out_data SHALL be 5 then 2, each 1 cycle after the transfer of pixels 5 and 7, and frame_done SHALL pulse with the value 2.
REQ-030 All-negative input {-128,-1,-2,-3 / -5,-6,-128,-4} SHALL produce -1 then -2, proving signed comparison.
REQ-031 Holding out_ready=0 after the first output SHALL drop in_ready to 0 and keep out_data stable; raising out_ready SHALL complete the transfer and reassert in_ready in the same cycle.
REQ-032 Two back-to-back frames with in_valid held high and out_ready=1 SHALL yield 4 outputs with no bubbles and no cross-frame mixing.
REQ-033 Asserting reset after 5 pixels, then sending a full frame, SHALL produce only the new frame's 2 results.
REQ-034 Random in_valid/out_ready toggling over 100 frames SHALL match a reference model, with exactly one frame_done per frame.
